// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t      : controller states (IDLE / BUSY / DONE)
//   mult_latency : number of BUSY iterations for a given operand width
//   count_width  : width of the iteration counter for a given operand width
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int unsigned mult_latency(input int unsigned width);
        return width;
    endfunction

    function automatic int unsigned count_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Accumulator / shift register and adder-subtractor for seq_multiplier.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   load     : capture multiplicand a and multiplier b, clear upper half
//   step     : perform one add-then-shift iteration
//   last     : current step is the final iteration (subtract in signed mode)
//   a, b     : multiplicand, multiplier (WIDTH bits)
//   sgn      : signed-mode select, captured on load (SEQ_MULT_SIGNED_EN only)
//   product  : accumulator contents (2*WIDTH bits)
// Configuration: `define SEQ_MULT_SIGNED_EN adds the sgn port and subtract path.
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 last,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 sgn,
`endif
    output logic [2*WIDTH-1:0]   product
);

    // Upper half holds the running partial product, lower half the
    // not-yet-consumed multiplier bits; sum[WIDTH] is the carry/sign
    // bit that lands at the top of the accumulator after the shift.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     sum;

`ifdef SEQ_MULT_SIGNED_EN
    logic               sgn_q;
    logic [WIDTH:0]     hi_x;
    logic [WIDTH:0]     a_x;

    always_comb begin
        hi_x = {sgn_q & acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
        a_x  = {sgn_q & mcand[WIDTH-1], mcand};
        sum  = hi_x;
        if (acc[0]) begin
            // Multiplier MSB carries negative weight in two's complement.
            sum = (sgn_q && last) ? (hi_x - a_x) : (hi_x + a_x);
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            sum = sum + {1'b0, mcand};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sgn_q <= 1'b0;
`endif
        end else if (load) begin
            acc   <= {{WIDTH{1'b0}}, b};
            mcand <= a;
`ifdef SEQ_MULT_SIGNED_EN
            sgn_q <= sgn;
`endif
        end else if (step) begin
            acc <= {sum, acc[WIDTH-1:1]};
        end
    end

    always_comb product = acc;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with valid/ready handshakes.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (A, B sampled on accept)
//   A, B                : multiplicand, multiplier (WIDTH bits)
//   out_valid/out_ready : result handshake
//   Product             : 2*WIDTH-bit result, stable while out_valid=1
//   busy                : iteration in progress
//   sgn                 : signed operands (only with SEQ_MULT_SIGNED_EN)
// Configuration: `define SEQ_MULT_SIGNED_EN for optional signed operation.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 busy
`ifdef SEQ_MULT_SIGNED_EN
    ,
    input  logic                 sgn
`endif
);

    localparam int unsigned     CW       = count_width(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(mult_latency(WIDTH) - 1);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   count;
    logic            load;
    logic            step;
    logic            last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load || last) begin
            count <= '0;
        end else if (step) begin
            count <= count + CW'(1);
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                step = 1'b1;
                last = (count == LAST_CNT);
                if (last) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    seq_mult_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .last    (last),
        .a       (A),
        .b       (B),
`ifdef SEQ_MULT_SIGNED_EN
        .sgn     (sgn),
`endif
        .product (Product)
    );

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       iv4, ir4, ov4, or4, busy4;
    logic [3:0] a4, b4;
    logic [7:0] p4;
    logic       iv8, ir8, ov8, or8, busy8;
    logic [7:0] a8, b8;
    logic [15:0] p8;
`ifdef SEQ_MULT_SIGNED_EN
    logic       sg4, sg8;
`endif

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
        .out_valid(ov4), .out_ready(or4), .Product(p4), .busy(busy4)
`ifdef SEQ_MULT_SIGNED_EN
        , .sgn(sg4)
`endif
    );

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .out_valid(ov8), .out_ready(or8), .Product(p8), .busy(busy8)
`ifdef SEQ_MULT_SIGNED_EN
        , .sgn(sg8)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer product, interpreted as two's complement when s=1.
    function automatic logic [15:0] model(input int unsigned w, input logic [7:0] a,
                                          input logic [7:0] b, input bit s);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 16'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic issue(input bit w8, input logic [7:0] a, input logic [7:0] b,
                         input bit s, output bit ok);
        int n = 0;
        if (w8) begin
            iv8 = 1'b1; a8 = a; b8 = b;
        end else begin
            iv4 = 1'b1; a4 = a[3:0]; b4 = b[3:0];
        end
`ifdef SEQ_MULT_SIGNED_EN
        if (w8) sg8 = s; else sg4 = s;
`endif
        while (!(w8 ? ir8 : ir4) && n < 100) begin
            tick;
            n++;
        end
        ok = (n < 100);
        tick;
        iv4 = 1'b0; iv8 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
        sg4 = 1'($urandom); sg8 = 1'($urandom);
`endif
    endtask

    task automatic wait_out(input bit w8, output int lat, output bit ok);
        lat = 0;
        while (!(w8 ? ov8 : ov4) && lat < 100) begin
            tick;
            lat++;
        end
        ok = (lat < 100);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        iv4 = 1'b0; iv8 = 1'b0; or4 = 1'b1; or8 = 1'b1;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
`ifdef SEQ_MULT_SIGNED_EN
        sg4 = 1'b0; sg8 = 1'b0;
`endif
        tick;
        tick;
        checks++; if (ir4 !== 1'b1)   begin failures++; $display("FAIL rst_in_ready4 got=%b want=1", ir4); end
        checks++; if (ov4 !== 1'b0)   begin failures++; $display("FAIL rst_out_valid4 got=%b want=0", ov4); end
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL rst_busy4 got=%b want=0", busy4); end
        checks++; if (p4 !== 8'd0)    begin failures++; $display("FAIL rst_product4 got=%0d want=0", p4); end
        checks++; if (ir8 !== 1'b1)   begin failures++; $display("FAIL rst_in_ready8 got=%b want=1", ir8); end
        checks++; if (ov8 !== 1'b0)   begin failures++; $display("FAIL rst_out_valid8 got=%b want=0", ov8); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL rst_busy8 got=%b want=0", busy8); end
        checks++; if (p8 !== 16'd0)   begin failures++; $display("FAIL rst_product8 got=%0d want=0", p8); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_max_operands;
        bit ok; int lat; logic [15:0] exp;
        exp = model(4, 8'd15, 8'd15, 1'b0);
        or4 = 1'b1;
        issue(1'b0, 8'd15, 8'd15, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL max_accept timeout got=0 want=1"); end
        checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL max_busy got=%b want=1", busy4); end
        wait_out(1'b0, lat, ok);
        checks++; if (!ok || lat != 4) begin failures++; $display("FAIL max_latency got=%0d want=4", lat); end
        checks++; if (p4 !== exp[7:0]) begin failures++; $display("FAIL max_product got=%0d want=%0d", p4, exp[7:0]); end
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL max_busy_done got=%b want=0", busy4); end
        tick;
        checks++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
            failures++; $display("FAIL max_return_idle got=ov%b/ir%b want=ov0/ir1", ov4, ir4);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] pa [4] = '{4'd0, 4'd1, 4'd2, 4'd11};
        logic [3:0] pb [4] = '{4'd9, 4'd3, 4'd5, 4'd13};
        int unsigned t_acc [4];
        bit ok; int lat, n; logic [15:0] exp;
        or4 = 1'b1;
        iv4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a4 = pa[i]; b4 = pb[i];
            n = 0;
            while (!ir4 && n < 100) begin tick; n++; end
            checks++; if (n >= 100) begin failures++; $display("FAIL b2b_accept timeout idx=%0d", i); end
            tick;
            t_acc[i] = cyc;
            a4 = 4'($urandom); b4 = 4'($urandom);
            if (i == 3) iv4 = 1'b0;
            wait_out(1'b0, lat, ok);
            exp = model(4, {4'd0, pa[i]}, {4'd0, pb[i]}, 1'b0);
            checks++; if (!ok || p4 !== exp[7:0]) begin
                failures++; $display("FAIL b2b_product idx=%0d got=%0d want=%0d", i, p4, exp[7:0]);
            end
        end
        iv4 = 1'b0;
        tick;
        for (int i = 1; i < 4; i++) begin
            checks++; if (t_acc[i] - t_acc[i-1] != 6) begin
                failures++; $display("FAIL b2b_spacing idx=%0d got=%0d want=6", i, t_acc[i] - t_acc[i-1]);
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok; int lat; logic [15:0] exp;
        exp = model(4, 8'd7, 8'd6, 1'b0);
        or4 = 1'b0;
        issue(1'b0, 8'd7, 8'd6, 1'b0, ok);
        wait_out(1'b0, lat, ok);
        checks++; if (!ok || lat != 4) begin failures++; $display("FAIL bp_latency got=%0d want=4", lat); end
        iv4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom);
            checks++; if (p4 !== exp[7:0] || ov4 !== 1'b1 || ir4 !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=p%0d/ov%b/ir%b want=p%0d/ov1/ir0", i, p4, ov4, ir4, exp[7:0]);
            end
            tick;
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        tick;
        checks++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
            failures++; $display("FAIL bp_release got=ov%b/ir%b want=ov0/ir1", ov4, ir4);
        end
        tick;
        checks++; if (ov4 !== 1'b0 || busy4 !== 1'b0 || ir4 !== 1'b1) begin
            failures++; $display("FAIL bp_idle got=ov%b/busy%b/ir%b want=ov0/busy0/ir1", ov4, busy4, ir4);
        end
    endtask

    task automatic test_reset_mid;
        bit ok; int lat; logic [15:0] exp;
        or4 = 1'b1;
        issue(1'b0, 8'd5, 8'd9, 1'b0, ok);
        tick;
        tick;
        rst = 1'b1;
        tick;
        checks++; if (ov4 !== 1'b0 || ir4 !== 1'b1 || p4 !== 8'd0 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_state got=ov%b/ir%b/p%0d/busy%b want=ov0/ir1/p0/busy0", ov4, ir4, p4, busy4);
        end
        rst = 1'b0;
        tick;
        checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL midrst_no_output got=%b want=0", ov4); end
        exp = model(4, 8'd3, 8'd3, 1'b0);
        issue(1'b0, 8'd3, 8'd3, 1'b0, ok);
        wait_out(1'b0, lat, ok);
        checks++; if (!ok || p4 !== exp[7:0]) begin
            failures++; $display("FAIL midrst_fresh got=%0d want=%0d", p4, exp[7:0]);
        end
        tick;
    endtask

    task automatic test_width8;
        logic [7:0] va [7];
        logic [7:0] vb [7];
        bit vs [7];
        bit ok; int lat; logic [15:0] exp;
        va[0] = 8'd255; vb[0] = 8'd255; vs[0] = 1'b0;
        va[1] = 8'd128; vb[1] = 8'd2;   vs[1] = 1'b0;
        for (int i = 2; i < 7; i++) begin
            va[i] = 8'($urandom); vb[i] = 8'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
            vs[i] = 1'($urandom);
`else
            vs[i] = 1'b0;
`endif
        end
        or8 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp = model(8, va[i], vb[i], vs[i]);
            issue(1'b1, va[i], vb[i], vs[i], ok);
            wait_out(1'b1, lat, ok);
            checks++; if (!ok || lat != 8) begin failures++; $display("FAIL w8_latency idx=%0d got=%0d want=8", i, lat); end
            checks++; if (p8 !== exp) begin
                failures++; $display("FAIL w8_product idx=%0d a=%0d b=%0d s=%0d got=%0d want=%0d", i, va[i], vb[i], vs[i], p8, exp);
            end
            tick;
        end
    endtask

    task automatic test_random;
        bit ok; int lat; int stall; bit s; logic [7:0] ra, rb; logic [15:0] exp;
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom_range(0, 15));
            rb = 8'($urandom_range(0, 15));
`ifdef SEQ_MULT_SIGNED_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            stall = $urandom_range(0, 3);
            exp = model(4, ra, rb, s);
            or4 = (stall == 0);
            issue(1'b0, ra, rb, s, ok);
            wait_out(1'b0, lat, ok);
            checks++; if (!ok || lat != 4) begin failures++; $display("FAIL rnd_latency idx=%0d got=%0d want=4", i, lat); end
            repeat (stall) tick;
            checks++; if (p4 !== exp[7:0] || ov4 !== 1'b1) begin
                failures++; $display("FAIL rnd_product idx=%0d a=%0d b=%0d s=%0d got=%0d want=%0d", i, ra, rb, s, p4, exp[7:0]);
            end
            or4 = 1'b1;
            tick;
        end
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed;
        logic [7:0] va [3] = '{8'd8, 8'd15, 8'd8};
        logic [7:0] vb [3] = '{8'd7, 8'd15, 8'd7};
        bit vs [3] = '{1'b1, 1'b1, 1'b0};
        bit ok; int lat; logic [15:0] exp;
        or4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = model(4, va[i], vb[i], vs[i]);
            issue(1'b0, va[i], vb[i], vs[i], ok);
            wait_out(1'b0, lat, ok);
            checks++; if (!ok || lat != 4 || p4 !== exp[7:0]) begin
                failures++; $display("FAIL signed idx=%0d got=%0d lat=%0d want=%0d lat=4", i, p4, lat, exp[7:0]);
            end
            tick;
        end
    endtask
`endif

    initial begin
        test_reset;
        test_max_operands;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        test_width8;
        test_random;
`ifdef SEQ_MULT_SIGNED_EN
        test_signed;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
